// File: rtl/tile_flush_sched.sv
// Frame-level sequencer for a two-bank tile RAM shared by the rasterizer and
// the tile writer. Walks the tile grid in raster order, hands free banks to
// the renderer, hands filled banks to the writer with the tile's framebuffer
// address, and reports frame completion once the writer FIFO has drained.
module tile_flush_sched #(
    parameter int TILE_W_BYTES = 64,
    parameter int TILE_H       = 32,
    parameter int CW           = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_frame_start,
    input  logic [31:0]   i_fb_base,
    input  logic [15:0]   i_fb_stride,
    input  logic [CW-1:0] i_tiles_x,
    input  logic [CW-1:0] i_tiles_y,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_rnd_go,
    output logic [CW-1:0] o_rnd_tx,
    output logic [CW-1:0] o_rnd_ty,
    output logic          o_rnd_bank,
    input  logic          i_rnd_done,
    output logic          o_wr_start,
    output logic [31:0]   o_wr_addr,
    output logic [15:0]   o_wr_stride,
    output logic          o_wr_bank,
    input  logic          i_wr_reading,
    input  logic          i_wr_flushed
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_START = 2'd1;
    localparam logic [1:0] W_HI    = 2'd2;
    localparam logic [1:0] W_LO    = 2'd3;

    localparam logic [1:0] B_FREE  = 2'd0;
    localparam logic [1:0] B_REND  = 2'd1;
    localparam logic [1:0] B_FULL  = 2'd2;
    localparam logic [1:0] B_WRIT  = 2'd3;

    localparam logic [31:0] TILE_STEP = 32'(TILE_W_BYTES);
    localparam logic [31:0] ROW_MUL   = 32'(TILE_H);

    logic [1:0]    r_state;
    logic [1:0]    r_wstate;
    logic [1:0]    r_bank_st [0:1];
    logic [31:0]   r_addr_q  [0:1];
    logic          r_rptr;
    logic          r_wptr;
    logic          r_rnd_busy;
    logic [CW-1:0] r_tx;
    logic [CW-1:0] r_ty;
    logic [CW-1:0] r_tiles_x;
    logic [CW-1:0] r_tiles_y;
    logic [31:0]   r_row_base;
    logic [31:0]   r_tile_addr;
    logic [15:0]   r_stride;
    logic          r_frame_done;
    logic          r_rnd_go;
    logic [CW-1:0] r_rnd_tx;
    logic [CW-1:0] r_rnd_ty;
    logic          r_rnd_bank;
    logic          r_wr_start;
    logic [31:0]   r_wr_addr;
    logic          r_wr_bank;

    logic          w_issue;
    logic          w_last_x;
    logic          w_last_y;
    logic          w_rnd_fin;
    logic          w_wr_claim;
    logic          w_release;
    logic [31:0]   w_row_step;
    logic [31:0]   w_row_next;

    // Stride is zero-extended before scaling to a full tile-row step; all
    // address sums wrap modulo 2^32.
    assign w_row_step = {16'd0, r_stride} * ROW_MUL;
    assign w_row_next = r_row_base + w_row_step;

    assign w_issue    = (r_state == S_RUN) && !r_rnd_busy && (r_bank_st[r_rptr] == B_FREE);
    assign w_last_x   = (r_tx == r_tiles_x - CW'(1));
    assign w_last_y   = (r_ty == r_tiles_y - CW'(1));
    assign w_rnd_fin  = i_rnd_done && r_rnd_busy;
    assign w_wr_claim = (r_wstate == W_START);
    assign w_release  = (r_wstate == W_LO) && !i_wr_reading;

    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;
    assign o_rnd_go     = r_rnd_go;
    assign o_rnd_tx     = r_rnd_tx;
    assign o_rnd_ty     = r_rnd_ty;
    assign o_rnd_bank   = r_rnd_bank;
    assign o_wr_start   = r_wr_start;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_stride  = r_stride;
    assign o_wr_bank    = r_wr_bank;

    // Main sequencer: frame capture, raster walk with render issue, drain, done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_rptr       <= 1'b0;
            r_rnd_busy   <= 1'b0;
            r_tx         <= '0;
            r_ty         <= '0;
            r_tiles_x    <= '0;
            r_tiles_y    <= '0;
            r_row_base   <= '0;
            r_tile_addr  <= '0;
            r_stride     <= '0;
            r_frame_done <= 1'b0;
            r_rnd_go     <= 1'b0;
            r_rnd_tx     <= '0;
            r_rnd_ty     <= '0;
            r_rnd_bank   <= 1'b0;
            r_addr_q[0]  <= '0;
            r_addr_q[1]  <= '0;
        end else begin
            r_rnd_go     <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_rnd_fin) begin
                r_rnd_busy <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_stride    <= i_fb_stride;
                        r_tiles_x   <= i_tiles_x;
                        r_tiles_y   <= i_tiles_y;
                        r_tx        <= '0;
                        r_ty        <= '0;
                        r_row_base  <= i_fb_base;
                        r_tile_addr <= i_fb_base;
                        if ((i_tiles_x == '0) || (i_tiles_y == '0)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_rnd_go          <= 1'b1;
                        r_rnd_tx          <= r_tx;
                        r_rnd_ty          <= r_ty;
                        r_rnd_bank        <= r_rptr;
                        r_rnd_busy        <= 1'b1;
                        r_addr_q[r_rptr]  <= r_tile_addr;
                        r_rptr            <= ~r_rptr;
                        if (w_last_x) begin
                            r_tx        <= '0;
                            r_ty        <= r_ty + CW'(1);
                            r_row_base  <= w_row_next;
                            r_tile_addr <= w_row_next;
                            if (w_last_y) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_tx        <= r_tx + CW'(1);
                            r_tile_addr <= r_tile_addr + TILE_STEP;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_bank_st[0] == B_FREE) && (r_bank_st[1] == B_FREE) &&
                        (r_wstate == W_IDLE) && i_wr_flushed) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_frame_done <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Writer handshake: claim the next full bank in order, pulse start, track the read window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wstate   <= W_IDLE;
            r_wptr     <= 1'b0;
            r_wr_start <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_bank  <= 1'b0;
        end else begin
            r_wr_start <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (r_bank_st[r_wptr] == B_FULL) begin
                        r_wr_bank <= r_wptr;
                        r_wr_addr <= r_addr_q[r_wptr];
                        r_wstate  <= W_START;
                    end
                end
                W_START: begin
                    r_wr_start <= 1'b1;
                    r_wstate   <= W_HI;
                end
                W_HI: begin
                    if (i_wr_reading) begin
                        r_wstate <= W_LO;
                    end
                end
                default: begin
                    if (!i_wr_reading) begin
                        r_wptr   <= ~r_wptr;
                        r_wstate <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Per-bank ownership; each transition needs a distinct prior state, so events on both banks combine.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bank_st[0] <= B_FREE;
            r_bank_st[1] <= B_FREE;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_issue && (r_rptr == 1'(b))) begin
                    r_bank_st[b] <= B_REND;
                end else if (w_rnd_fin && (r_rnd_bank == 1'(b))) begin
                    r_bank_st[b] <= B_FULL;
                end else if (w_wr_claim && (r_wptr == 1'(b))) begin
                    r_bank_st[b] <= B_WRIT;
                end else if (w_release && (r_wptr == 1'(b))) begin
                    r_bank_st[b] <= B_FREE;
                end
            end
        end
    end

endmodule
